// File: rtl/pipe_cpa_if.sv
// Handshake and operand/result bundle for the pipelined carry-propagate adder.
// master drives operands and out_ready; slave (the adder) returns results.
interface pipe_cpa_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_cpa.sv
// Pipelined carry-propagate adder/subtractor.
// Each stage adds one CHUNK-wide slice and registers its carry for the next
// stage. Operand slices not yet added travel down the pipe right-shifted so
// the next slice to add is always in the low bits; finished sum slices are
// kept in place so the whole word leaves the last stage together.
// Subtraction is folded in at entry (y inverted, carry-in forced to 1), so
// later stages never need to know the mode.
module pipe_cpa #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic      clk,
  input logic      rst_n,
  pipe_cpa_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  // Per-stage inputs: index k is what stage k's adder sees this cycle.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic             adv;
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  // The whole pipe moves as one unit; it only stalls when a result is
  // waiting and the consumer is not taking it.
  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

  assign a_in[0] = bus.x;
  assign b_in[0] = bus.sub ? ~bus.y : bus.y;
  assign c_in[0] = bus.sub | bus.cin;
  assign s_in[0] = '0;
  assign v_in[0] = bus.in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CHUNK:0]   chunk_add;
      logic [WIDTH-1:0] sum_next;

      // Add this stage's slice and splice it into the partial sum word.
      always_comb begin
        chunk_add = {1'b0, a_in[gi][CHUNK-1:0]} + {1'b0, b_in[gi][CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, c_in[gi]};
        sum_next = s_in[gi];
        sum_next[gi*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
      end

      if (gi < STAGES - 1) begin : g_mid
        logic [WIDTH-1:0] a_reg;
        logic [WIDTH-1:0] b_reg;
        logic [WIDTH-1:0] s_reg;
        logic             c_reg;
        logic             v_reg;

        // Skew/de-skew registers plus carry and valid for the next stage.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            c_reg <= 1'b0;
            v_reg <= 1'b0;
          end else if (adv) begin
            a_reg <= a_in[gi] >> CHUNK;
            b_reg <= b_in[gi] >> CHUNK;
            s_reg <= sum_next;
            c_reg <= chunk_add[CHUNK];
            v_reg <= v_in[gi];
          end
        end

        assign a_in[gi+1] = a_reg;
        assign b_in[gi+1] = b_reg;
        assign s_in[gi+1] = s_reg;
        assign c_in[gi+1] = c_reg;
        assign v_in[gi+1] = v_reg;
      end else begin : g_last
        logic ovf_next;

        // The top slice holds both operand MSBs, so overflow is decided here.
        assign ovf_next = (a_in[gi][CHUNK-1] == b_in[gi][CHUNK-1]) &&
                          (chunk_add[CHUNK-1] != a_in[gi][CHUNK-1]);

        // Output registers drive the result ports directly.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
          end else if (adv) begin
            out_valid_reg <= v_in[gi];
            sum_reg       <= sum_next;
            cout_reg      <= chunk_add[CHUNK];
            ovf_reg       <= ovf_next;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_pipe_cpa.sv
// Self-checking bench for pipe_cpa (WIDTH=16, STAGES=4): directed cases,
// back-to-back and stalled traffic, reset flush, and a long random run
// checked against an integer-arithmetic scoreboard.
module tb_pipe_cpa;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_cpa_if #(.WIDTH(WIDTH)) bus ();
  pipe_cpa #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } res_t;

  res_t q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int pops = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected result from plain integer arithmetic on the operands.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic s);
    res_t r;
    int full;
    int sres;
    full = s ? int'(a) + 65536 - int'(b) : int'(a) + int'(b) + int'(ci);
    sres = s ? int'($signed(a)) - int'($signed(b))
             : int'($signed(a)) + int'($signed(b)) + int'(ci);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (sres > 32767) || (sres < -32768);
    r.acc  = 0;
    return r;
  endfunction

  // Scoreboard: checks handshake rule, hold stability and every result.
  logic        held = 1'b0;
  logic [17:0] held_val;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      chk("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
      if (held) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", {14'd0, bus.sum, bus.cout, bus.ovf}, {14'd0, held_val});
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = q[0];
          chk("result", {14'd0, bus.sum, bus.cout, bus.ovf}, {14'd0, e.sum, e.cout, e.ovf});
          chk("not_early", {31'd0, (cyc - e.acc) >= STAGES}, 32'd1);
          if (bus.out_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
      held = bus.out_valid && !bus.out_ready;
      held_val = {bus.sum, bus.cout, bus.ovf};
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.x, bus.y, bus.cin, bus.sub);
        e.acc = cyc;
        q.push_back(e);
        chk("occupancy", {31'd0, q.size() <= STAGES}, 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    bus.x   = 16'($urandom);
    bus.y   = 16'($urandom);
    bus.cin = 1'($urandom_range(0, 1));
    bus.sub = 1'($urandom_range(0, 1));
  endtask

  // One isolated transaction with exact latency and literal result checks.
  task automatic run_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    step();
    bus.x = a; bus.y = b; bus.cin = ci; bus.sub = s;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    chk({nm, "_latency"}, lat, STAGES);
    chk({nm, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, last, acc;
    res_t m;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Pin the model against hand-computed values
    m = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("model_wrap", {14'd0, m.sum, m.cout, m.ovf}, {14'd0, 16'h0000, 1'b1, 1'b0});
    m = model(16'h0005, 16'h0007, 1'b1, 1'b1);
    chk("model_sub", {14'd0, m.sum, m.cout, m.ovf}, {14'd0, 16'hFFFE, 1'b0, 1'b0});
    m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("model_ovf", {14'd0, m.sum, m.cout, m.ovf}, {14'd0, 16'h8000, 1'b0, 1'b1});

    // Directed arithmetic cases
    run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Ten back-to-back transactions: results on ten consecutive cycles
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      bus.out_ready = 1'b1;
      bus.in_valid = (i < 10);
      rand_ops();
      @(negedge clk);
      if (bus.out_valid) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("b2b_count", n, 10);
    chk("b2b_first", first, 4);
    chk("b2b_last", last, 13);

    // Stall with out_ready low: exactly STAGES accepted
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.in_valid = 1'b1;
      rand_ops();
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
    end
    chk("stall_accepted", acc, STAGES);
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    bus.out_ready = 1'b1;
    rand_ops();
    @(negedge clk);
    chk("resume_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("resume_out_valid", {31'd0, bus.out_valid}, 32'd1);
    repeat (3) begin
      step();
      rand_ops();
    end
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();

    // Reset mid-flight discards everything
    for (int i = 0; i < 3; i++) begin
      step();
      bus.in_valid = 1'b1;
      rand_ops();
    end
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("flush_no_ghost", n, 0);
    run_one("post_flush", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Long random run with random back-pressure
    for (int i = 0; i < 10000; i++) begin
      step();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rand_ops();
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("drained", q.size(), 0);
    chk("random_traffic_seen", {31'd0, pops > 5000}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
